// File: rtl/ssd_mux_driver.sv
// Time-multiplexed hex driver for a bank of common-anode 7-segment digits.
// Frame-buffered load, leading-zero blanking, per-digit decimal point and blink.
module ssd_mux_driver #(
   parameter int NUM_DIGITS     = 4,
   parameter int CLK_DIV        = 50000,
   parameter int BLINK_FRAMES   = 64,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ld,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blink_en,
   input  logic                    blank_lz,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int PS_W  = $clog2(CLK_DIV);
   localparam int BL_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [BL_W-1:0]  BL_LAST  = BL_W'(BLINK_FRAMES - 1);

   localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
   localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

   logic [PS_W-1:0]         presc;
   logic [IDX_W-1:0]        idx;
   logic [BL_W-1:0]         blink_cnt;
   logic                    blink_phase;
   logic                    pending;
   logic [4*NUM_DIGITS-1:0] shadow_data, active_data;
   logic [NUM_DIGITS-1:0]   shadow_dp, active_dp;
   logic [NUM_DIGITS-1:0]   shadow_blink, active_blink;

   logic                    slot_end;
   logic                    frame_end;
   logic [3:0]              nib;
   logic                    lz_blank;
   logic                    blanked;
   logic [6:0]              seg_low;
   logic                    dp_low;
   logic [NUM_DIGITS-1:0]   an_low;
   logic [6:0]              seg_nxt;
   logic                    dp_nxt;
   logic [NUM_DIGITS-1:0]   an_nxt;

   // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
   function automatic logic [6:0] decode(input logic [3:0] v);
      case (v)
         4'h0: decode = 7'b1000000;
         4'h1: decode = 7'b1111001;
         4'h2: decode = 7'b0100100;
         4'h3: decode = 7'b0110000;
         4'h4: decode = 7'b0011001;
         4'h5: decode = 7'b0010010;
         4'h6: decode = 7'b0000010;
         4'h7: decode = 7'b1111000;
         4'h8: decode = 7'b0000000;
         4'h9: decode = 7'b0010000;
         4'hA: decode = 7'b0001000;
         4'hB: decode = 7'b0000011;
         4'hC: decode = 7'b1000110;
         4'hD: decode = 7'b0100001;
         4'hE: decode = 7'b0000110;
         default: decode = 7'b0001110;
      endcase
   endfunction

   assign slot_end  = (presc == PS_LAST);
   assign frame_end = slot_end && (idx == IDX_LAST);

   // NOTE: state is updated with non-blocking assignments so every register
   // samples pre-edge values and simulation matches the synthesized flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc       <= '0;
         idx         <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else begin
         presc <= slot_end ? '0 : presc + 1'b1;
         if (slot_end)
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         if (frame_end) begin
            if (blink_cnt == BL_LAST) begin
               blink_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end
      end
   end

   // NOTE: the frame buffers are reset too, so a reset (even mid-frame) drops
   // any pending load and the bank comes back showing zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending      <= 1'b0;
         shadow_data  <= '0;
         shadow_dp    <= '0;
         shadow_blink <= '0;
         active_data  <= '0;
         active_dp    <= '0;
         active_blink <= '0;
      end else begin
         if (ld) begin
            shadow_data  <= data_in;
            shadow_dp    <= dp_in;
            shadow_blink <= blink_en;
         end
         if (frame_end) begin
            pending      <= 1'b0;
            active_data  <= ld ? data_in  : shadow_data;
            active_dp    <= ld ? dp_in    : shadow_dp;
            active_blink <= ld ? blink_en : shadow_blink;
         end else if (ld) begin
            pending <= 1'b1;
         end
      end
   end

   // NOTE: every signal gets a value at the top of the block so no path
   // through it can leave one unassigned and infer a latch.
   always_comb begin
      nib      = active_data[{idx, 2'b00} +: 4];
      lz_blank = blank_lz && (idx != '0);
      for (int j = 0; j < NUM_DIGITS; j++) begin
         if (j >= int'(idx) && active_data[4*j +: 4] != 4'h0)
            lz_blank = 1'b0;
      end
      blanked = lz_blank || (blink_phase && active_blink[idx]);
      seg_low = blanked ? 7'h7F : decode(nib);
      dp_low  = blanked || !active_dp[idx];
      // First cycle of each slot keeps all anodes off to hide the segment change.
      an_low  = '1;
      if (presc != '0)
         an_low[idx] = 1'b0;
      seg_nxt = (SEG_ACTIVE_LOW != 0) ? seg_low : ~seg_low;
      dp_nxt  = (SEG_ACTIVE_LOW != 0) ? dp_low  : ~dp_low;
      an_nxt  = (AN_ACTIVE_LOW  != 0) ? an_low  : ~an_low;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seg        <= SEG_OFF;
         dp         <= DP_OFF;
         an         <= AN_OFF;
         frame_done <= 1'b0;
      end else begin
         seg        <= seg_nxt;
         dp         <= dp_nxt;
         an         <= an_nxt;
         frame_done <= frame_end;
      end
   end

endmodule

// File: tb/tb_ssd_mux_driver.sv
// Directed bench for ssd_mux_driver: 4 digits, 4 clocks per slot, blink every 2 frames.
// Cycle k after reset release shows slot (k-1)%16; a frame ends on every 16th edge.
module tb_ssd_mux_driver;

   logic        clk = 1'b0;
   logic        rst;
   logic        ld;
   logic [15:0] data_in;
   logic [3:0]  dp_in;
   logic [3:0]  blink_en;
   logic        blank_lz;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_done;

   int checks   = 0;
   int errors   = 0;
   int cyc      = 0;
   bit track_fd = 1'b0;

   logic [3:0] an_exp [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

   ssd_mux_driver #(
      .NUM_DIGITS    (4),
      .CLK_DIV       (4),
      .BLINK_FRAMES  (2),
      .SEG_ACTIVE_LOW(1),
      .AN_ACTIVE_LOW (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ld        (ld),
      .data_in   (data_in),
      .dp_in     (dp_in),
      .blink_en  (blink_en),
      .blank_lz  (blank_lz),
      .seg       (seg),
      .dp        (dp),
      .an        (an),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock; outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (track_fd)
         check($sformatf("frame_done@%0d", cyc), frame_done, (cyc % 16 == 0) ? 1 : 0);
   endtask

   task automatic wait_to(input int k);
      while (cyc < k) tick();
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_seg"}, seg, 7'h7F);
      check({tag, "_dp"},  dp,  1'b1);
      check({tag, "_an"},  an,  4'hF);
      check({tag, "_fd"},  frame_done, 1'b0);
   endtask

   task automatic check_slot(input int m, input int s, input logic [6:0] e_seg, input logic e_dp);
      wait_to(16*m + 4*s + 1);
      check($sformatf("f%0d_s%0d_gap_an", m, s), an, 4'hF);
      tick();
      check($sformatf("f%0d_s%0d_an",  m, s), an,  an_exp[s]);
      check($sformatf("f%0d_s%0d_seg", m, s), seg, e_seg);
      check($sformatf("f%0d_s%0d_dp",  m, s), dp,  e_dp);
   endtask

   initial begin
      rst      = 1'b1;
      ld       = 1'b0;
      data_in  = 16'h0000;
      dp_in    = 4'b0000;
      blink_en = 4'b0000;
      blank_lz = 1'b0;

      // Reset held for three cycles
      for (int i = 0; i < 3; i++) begin
         tick();
         check_reset($sformatf("rst%0d", i));
      end
      rst      = 1'b0;
      cyc      = 0;
      track_fd = 1'b1;

      tick();
      check("rel1_an", an, 4'hF);
      tick();
      check("rel2_an",  an,  4'hE);
      check("rel2_seg", seg, 7'h40);
      check("rel2_dp",  dp,  1'b1);

      // Load 12A0 mid-frame: frame 0 keeps showing zeros, frame 1 shows it
      data_in = 16'h12A0;
      ld      = 1'b1;
      tick();
      ld = 1'b0;
      wait_to(10);
      check("f0_s2_old_an",  an,  4'hB);
      check("f0_s2_old_seg", seg, 7'h40);
      check_slot(1, 0, 7'h40, 1'b1);
      check_slot(1, 1, 7'h08, 1'b1);
      check_slot(1, 2, 7'h24, 1'b1);
      check_slot(1, 3, 7'h79, 1'b1);

      // Leading-zero blanking
      blank_lz = 1'b1;
      data_in  = 16'h0050;
      ld       = 1'b1;
      tick();
      ld = 1'b0;
      check_slot(2, 0, 7'h40, 1'b1);
      check_slot(2, 1, 7'h12, 1'b1);
      check_slot(2, 2, 7'h7F, 1'b1);
      check_slot(2, 3, 7'h7F, 1'b1);

      data_in = 16'h0000;
      ld      = 1'b1;
      tick();
      ld = 1'b0;
      check_slot(3, 0, 7'h40, 1'b1);
      check_slot(3, 1, 7'h7F, 1'b1);

      // Mid-frame load, then a load on the frame-end cycle itself
      wait_to(56);
      data_in = 16'h1111;
      ld      = 1'b1;
      tick();
      ld = 1'b0;
      check_slot(3, 3, 7'h7F, 1'b1);
      wait_to(63);
      data_in = 16'h2222;
      ld      = 1'b1;
      tick();
      ld = 1'b0;
      check_slot(4, 0, 7'h24, 1'b1);
      check_slot(4, 1, 7'h24, 1'b1);

      // Blink on digit 0, decimal point on digit 1
      blink_en = 4'b0001;
      dp_in    = 4'b0010;
      ld       = 1'b1;
      tick();
      ld = 1'b0;
      check_slot(4, 3, 7'h24, 1'b1);
      for (int m = 5; m <= 8; m++) begin
         check_slot(m, 0, (m == 6 || m == 7) ? 7'h7F : 7'h24, 1'b1);
         check_slot(m, 1, 7'h24, 1'b0);
      end

      // Reset during slot 2 with a load pending
      wait_to(146);
      data_in = 16'hBEEF;
      ld      = 1'b1;
      tick();
      ld = 1'b0;
      wait_to(153);
      rst      = 1'b1;
      track_fd = 1'b0;
      tick();
      check_reset("midrst0");
      tick();
      check_reset("midrst1");
      rst      = 1'b0;
      cyc      = 0;
      track_fd = 1'b1;

      check_slot(0, 0, 7'h40, 1'b1);
      check_slot(0, 1, 7'h7F, 1'b1);
      check_slot(0, 3, 7'h7F, 1'b1);
      check_slot(1, 0, 7'h40, 1'b1);
      check_slot(1, 1, 7'h7F, 1'b1);
      check_slot(1, 2, 7'h7F, 1'b1);
      blank_lz = 1'b0;
      check_slot(1, 3, 7'h40, 1'b1);
      wait_to(33);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
